// File: rtl/cpu_0_mulx_seq.sv
// Sequential 32x32->64 multiplier using one external 32-bit cell over four 16x16 passes.
// Latency: start in cycle 0, done pulse in cycle 6+CELL_LATENCY; one result per 6+CELL_LATENCY cycles.
// Backpressure: start ignored while busy; start accepted in IDLE and in the DONE cycle.
module cpu_0_mulx_seq #(
    parameter int CELL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_a,
    input  logic        signed_b,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_cell_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo
);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FIX, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sa_q;
    logic        sb_q;
    logic [1:0]  pass_q;
    logic [63:0] acc;
    logic        accept;

    // In-flight tracking: stage CELL_LATENCY-1 lines up with the cell result of that pass.
    logic [CELL_LATENCY-1:0]      fl_vld;
    logic [CELL_LATENCY-1:0][1:0] fl_idx;
    logic                         arr_vld;
    logic [1:0]                   arr_idx;
    logic [63:0]                  partial;
    logic [31:0]                  corr_a;
    logic [31:0]                  corr_b;

    assign accept  = start && (state == IDLE || state == DONE);
    assign arr_vld = fl_vld[CELL_LATENCY-1];
    assign arr_idx = fl_idx[CELL_LATENCY-1];
    assign busy    = (state == ISSUE) || (state == DRAIN) || (state == FIX);
    assign done    = (state == DONE);

    // Two's complement correction of the high word from the unsigned product.
    assign corr_a = (sa_q && a_q[31]) ? b_q : 32'd0;
    assign corr_b = (sb_q && b_q[31]) ? a_q : 32'd0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; DONE accepts a new start like IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (pass_q == 2'd3) state_nx = DRAIN;
            DRAIN:   if (arr_vld && arr_idx == 2'd3) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = start ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Cell operands: one 16x16 half-word pair per ISSUE cycle, zero otherwise.
    always_comb begin
        mul_src1 = 32'd0;
        mul_src2 = 32'd0;
        if (state == ISSUE) begin
            case (pass_q)
                2'd0: begin mul_src1 = {16'd0, a_q[15:0]};  mul_src2 = {16'd0, b_q[15:0]};  end
                2'd1: begin mul_src1 = {16'd0, a_q[15:0]};  mul_src2 = {16'd0, b_q[31:16]}; end
                2'd2: begin mul_src1 = {16'd0, a_q[31:16]}; mul_src2 = {16'd0, b_q[15:0]};  end
                default: begin mul_src1 = {16'd0, a_q[31:16]}; mul_src2 = {16'd0, b_q[31:16]}; end
            endcase
        end
    end

    // Align the arriving partial product to its weight in the 64-bit sum.
    always_comb begin
        partial = 64'd0;
        case (arr_idx)
            2'd0:    partial = {32'd0, mul_cell_result};
            2'd3:    partial = {mul_cell_result, 32'd0};
            default: partial = {16'd0, mul_cell_result, 16'd0};
        endcase
    end

    // Operand capture, pass counter and partial-product accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            pass_q <= 2'd0;
            acc    <= 64'd0;
        end else if (accept) begin
            a_q    <= src1;
            b_q    <= src2;
            sa_q   <= signed_a;
            sb_q   <= signed_b;
            pass_q <= 2'd0;
            acc    <= 64'd0;
        end else begin
            if (state == ISSUE) pass_q <= pass_q + 2'd1;
            if (arr_vld)        acc    <= acc + partial;
        end
    end

    // In-flight shift register; cleared by reset so late cell results are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            fl_vld <= '0;
            fl_idx <= '0;
        end else begin
            fl_vld[0] <= (state == ISSUE);
            fl_idx[0] <= pass_q;
            for (int i = 1; i < CELL_LATENCY; i++) begin
                fl_vld[i] <= fl_vld[i-1];
                fl_idx[i] <= fl_idx[i-1];
            end
        end
    end

    // Result register: loaded only in FIX, so it holds until the next operation's FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_hi <= 32'd0;
            result_lo <= 32'd0;
        end else if (state == FIX) begin
            result_hi <= acc[63:32] - corr_a - corr_b;
            result_lo <= acc[31:0];
        end
    end

endmodule

// File: tb/tb_cpu_0_mulx_seq.sv
// Bench for cpu_0_mulx_seq: three instances with CELL_LATENCY 1, 2, 3, each with a cell model.
// Expected products are queued at issue and compared with value and cycle when done pulses.
// Instance 0 carries the directed scenarios; all three run random back-to-back traffic.
module tb_cpu_0_mulx_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  start = '0;
    logic [2:0]  sa = '0;
    logic [2:0]  sb = '0;
    logic [31:0] src1 [3];
    logic [31:0] src2 [3];
    logic [31:0] mul_src1 [3];
    logic [31:0] mul_src2 [3];
    logic [31:0] cell_res [3];
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [31:0] result_hi [3];
    logic [31:0] result_lo [3];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int active = 0;
    logic [63:0] exp_q [$];
    int          cyc_q [$];

    always #5 clk = ~clk;

    // Cycle counter; a cycle number names the period following the posedge that set it.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic [31:0] pipe [3];
        // Multiplier cell model delivering the low word k+1 cycles after the operands.
        always @(posedge clk) begin
            pipe[0] <= mul_src1[k] * mul_src2[k];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign cell_res[k] = pipe[k];

        cpu_0_mulx_seq #(.CELL_LATENCY(k + 1)) u_dut (
            .clk             (clk),
            .reset           (reset),
            .start           (start[k]),
            .signed_a        (sa[k]),
            .signed_b        (sb[k]),
            .src1            (src1[k]),
            .src2            (src2[k]),
            .mul_src1        (mul_src1[k]),
            .mul_src2        (mul_src2[k]),
            .mul_cell_result (cell_res[k]),
            .busy            (busy[k]),
            .done            (done[k]),
            .result_hi       (result_hi[k]),
            .result_lo       (result_lo[k])
        );
    end

    function automatic logic [63:0] ref_mul(input logic sa_i, input logic sb_i,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa_i ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sb_i ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle on instance k; optionally queue the expected product and done cycle.
    task automatic issue(input int k, input logic sa_i, input logic sb_i,
                         input logic [31:0] a, input logic [31:0] b, input bit push);
        sa[k]   = sa_i;
        sb[k]   = sb_i;
        src1[k] = a;
        src2[k] = b;
        start[k] = 1'b1;
        if (push) begin
            exp_q.push_back(ref_mul(sa_i, sb_i, a, b));
            cyc_q.push_back(cyc + 7 + k);
        end
        tick();
        start[k] = 1'b0;
    endtask

    // Scoreboard: every done pulse must match the head of the queue in value and cycle.
    task automatic sb_monitor();
        logic [63:0] e;
        int          ec;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (done[k] === 1'b1) begin
                    checks++;
                    if (k != active || exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL done_unexpected inst=%0d cyc=%0d", k, cyc);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = cyc_q.pop_front();
                        if ({result_hi[k], result_lo[k]} !== e || cyc != ec) begin
                            failures++;
                            $display("FAIL product inst=%0d got=%h@%0d exp=%h@%0d",
                                     k, {result_hi[k], result_lo[k]}, cyc, e, ec);
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy[k], done[k], mul_src1[k], mul_src2[k], result_hi[k], result_lo[k]} !== '0) begin
                failures++;
                $display("FAIL reset_state inst=%0d busy=%b done=%b ms1=%h ms2=%h hi=%h lo=%h exp=all0",
                         k, busy[k], done[k], mul_src1[k], mul_src2[k], result_hi[k], result_lo[k]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_passes();
        logic [31:0] e1 [6];
        logic [31:0] e2 [6];
        e1 = '{32'h5678, 32'h5678, 32'h1234, 32'h1234, 32'h0, 32'h0};
        e2 = '{32'hDEF0, 32'h9ABC, 32'hDEF0, 32'h9ABC, 32'h0, 32'h0};
        active = 0;
        issue(0, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            checks++;
            if (busy[0] !== (j <= 6)) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", j, busy[0], (j <= 6));
            end
            if (j <= 6) begin
                checks++;
                if (mul_src1[0] !== e1[j-1] || mul_src2[0] !== e2[j-1]) begin
                    failures++;
                    $display("FAIL cell_operands cyc=%0d got=%h,%h exp=%h,%h",
                             j, mul_src1[0], mul_src2[0], e1[j-1], e2[j-1]);
                end
            end
            tick();
        end
        wait_drain();
    endtask

    task automatic test_directed();
        active = 0;
        issue(0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_drain();
        checks++;
        if ({result_hi[0], result_lo[0]} !== 64'hFFFFFFFE_00000001) begin
            failures++;
            $display("FAIL unsigned_max got=%h exp=fffffffe00000001", {result_hi[0], result_lo[0]});
        end
        issue(0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_drain();
        issue(0, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 1'b1);
        wait_drain();
        checks++;
        if ({result_hi[0], result_lo[0]} !== 64'h40000000_00000000) begin
            failures++;
            $display("FAIL signed_min got=%h exp=4000000000000000", {result_hi[0], result_lo[0]});
        end
        issue(0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000002, 1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [63:0] first;
        active = 0;
        first = ref_mul(1'b0, 1'b1, 32'h12345678, 32'hF0F0F0F0);
        issue(0, 1'b0, 1'b1, 32'h12345678, 32'hF0F0F0F0, 1'b1);     // cycle 0
        tick();                                                      // cycle 2
        issue(0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h00000007, 1'b0);     // ignored
        tick();                                                      // cycle 4
        issue(0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0000FFFF, 1'b0);     // ignored
        tick();
        tick();                                                      // cycle 7, DONE
        issue(0, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 1'b1);
        for (int j = 8; j <= 13; j++) begin
            checks++;
            if ({result_hi[0], result_lo[0]} !== first) begin
                failures++;
                $display("FAIL result_hold cyc=%0d got=%h exp=%h", j, {result_hi[0], result_lo[0]}, first);
            end
            tick();
        end
        wait_drain();
    endtask

    task automatic test_reset_abort();
        active = 0;
        issue(0, 1'b1, 1'b0, 32'h87654321, 32'h13579BDF, 1'b0);     // now cycle 1
        tick();
        tick();                                                      // cycle 3
        reset = 1'b1;
        tick();
        checks++;
        if ({busy[0], done[0], mul_src1[0], mul_src2[0], result_hi[0], result_lo[0]} !== '0) begin
            failures++;
            $display("FAIL abort_state busy=%b done=%b ms1=%h ms2=%h hi=%h lo=%h exp=all0",
                     busy[0], done[0], mul_src1[0], mul_src2[0], result_hi[0], result_lo[0]);
        end
        reset = 1'b0;
        repeat (12) tick();
        issue(0, 1'b0, 1'b0, 32'h0000BEEF, 32'h00C0FFEE, 1'b1);
        wait_drain();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h80000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h00000000;
            default: return $urandom();
        endcase
    endfunction

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            active = k;
            for (int n = 0; n < 16; n++) begin
                issue(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(), 1'b1);
                repeat (5 + k + 1) tick();                           // DONE cycle
                if ($urandom_range(0, 1) == 0) tick();
            end
            wait_drain();
        end
    endtask

    initial begin
        src1 = '{32'd0, 32'd0, 32'd0};
        src2 = '{32'd0, 32'd0, 32'd0};
        fork
            sb_monitor();
        join_none
        test_reset();
        test_passes();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
